// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: response ownership
// encoding, default parameters and a counter-width helper.
package mem_arbiter_pkg;

  localparam int DEPTH_DEFAULT      = 10;
  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int DATA_W             = 32;
  localparam int BE_W               = DATA_W / 8;

  // Which port the RAM access issued last cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Everything needed one cycle after a grant to route the RAM read data.
  typedef struct packed {
    owner_e owner;
    logic   write;
  } rsp_tag_t;

  // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of an external single-port synchronous RAM.
// The data port normally has priority; a saturating starvation counter
// forces a fetch grant once the fetch port has lost STARVE_MAX times in a
// row. Responses come back exactly one cycle after the grant on the port
// that owned the access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_valid,
  input  logic [DEPTH-1:0]  if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,

  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [DEPTH-1:0]  d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [BE_W-1:0]   d_req_be,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,

  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [DEPTH-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int             CNT_W   = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  owner_e           grant;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  rsp_tag_t         rsp_tag;
  rsp_tag_t         rsp_tag_nxt;

  // Pick at most one winner this cycle from the valids and the starvation count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant = OWN_NONE;
    // NOTE: rst_n gates the grant combinationally so ready and mem_en stay low
    // for the whole reset interval, not just after the next clock edge.
    if (rst_n) begin
      if (if_req_valid && d_req_valid) begin
        grant = (starve_cnt == CNT_MAX) ? OWN_IF : OWN_D;
      end else if (d_req_valid) begin
        grant = OWN_D;
      end else if (if_req_valid) begin
        grant = OWN_IF;
      end
    end
  end

  assign if_req_ready = (grant == OWN_IF);
  assign d_req_ready  = (grant == OWN_D);

  // Drive the RAM port from the winner; everything is zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (grant)
      OWN_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_req_addr;
      end
      OWN_D: begin
        mem_en    = 1'b1;
        mem_addr  = d_req_addr;
        mem_wdata = d_req_wdata;
        mem_we    = d_req_we ? d_req_be : '0;
      end
      default: ;
    endcase
  end

  // Next starvation count and the tag describing the access issued now.
  always_comb begin
    starve_cnt_nxt = '0;
    if (if_req_valid && (grant != OWN_IF)) begin
      starve_cnt_nxt = (starve_cnt == CNT_MAX) ? starve_cnt
                                               : starve_cnt + CNT_W'(1);
    end
    rsp_tag_nxt.owner = grant;
    rsp_tag_nxt.write = (grant == OWN_D) && d_req_we;
  end

  // Register the starvation count and response tag; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt    <= '0;
      rsp_tag.owner <= OWN_NONE;
      rsp_tag.write <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before this edge, regardless of statement order.
      starve_cnt <= starve_cnt_nxt;
      rsp_tag    <= rsp_tag_nxt;
    end
  end

  // Route RAM read data to the owning port; write acks and non-owners read 0.
  always_comb begin
    if_rsp_valid = (rsp_tag.owner == OWN_IF);
    d_rsp_valid  = (rsp_tag.owner == OWN_D);
    if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
    d_rsp_data   = (d_rsp_valid && !rsp_tag.write) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM alongside it.
// Stimulus pushes expected responses into per-port queues; a monitor on the
// falling edge pops and compares whenever a response is due.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DEPTH = 10;

  logic              clk;
  logic              rst_n;
  logic              if_req_valid;
  logic [DEPTH-1:0]  if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              d_req_valid;
  logic              d_req_we;
  logic [DEPTH-1:0]  d_req_addr;
  logic [31:0]       d_req_wdata;
  logic [3:0]        d_req_be;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [DEPTH-1:0]  mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  mem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX_DEFAULT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .d_req_valid  (d_req_valid),
    .d_req_we     (d_req_we),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_req_be     (d_req_be),
    .d_req_ready  (d_req_ready),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_data   (d_rsp_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural single-port RAM: byte-enabled writes, one-cycle read latency.
  logic [31:0] ram [0:(1<<DEPTH)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'b0000) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: each falling edge, a response is due exactly when the queue head says so.
  exp_t if_e, d_e;
  bit   if_due, d_due;
  always @(negedge clk) begin
    if_due = (if_q.size() > 0) && (if_q[0].due == cyc);
    d_due  = (d_q.size()  > 0) && (d_q[0].due  == cyc);
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(if_due));
    check("d_rsp_valid",  32'(d_rsp_valid),  32'(d_due));
    if (if_due) begin
      if_e = if_q.pop_front();
      check("if_rsp_data", if_rsp_data, if_e.data);
    end else begin
      check("if_rsp_data_idle", if_rsp_data, 32'h0);
    end
    if (d_due) begin
      d_e = d_q.pop_front();
      check("d_rsp_data", d_rsp_data, d_e.data);
    end else begin
      check("d_rsp_data_idle", d_rsp_data, 32'h0);
    end
  end

  // One request cycle: drive, check grant and RAM strobes, queue the response.
  task automatic step(input logic ifv, input logic [DEPTH-1:0] ifa,
                      input logic dv, input logic dwe, input logic [DEPTH-1:0] da,
                      input logic [31:0] dwd, input logic [3:0] dbe,
                      input owner_e exp_gnt, input logic [31:0] exp_rsp,
                      input bit queue_rsp = 1'b1);
    logic [3:0] exp_we;
    exp_t       e;
    if_req_valid = ifv;
    if_req_addr  = ifa;
    d_req_valid  = dv;
    d_req_we     = dwe;
    d_req_addr   = da;
    d_req_wdata  = dwd;
    d_req_be     = dbe;
    @(negedge clk);
    check("if_req_ready", 32'(if_req_ready), 32'(exp_gnt == OWN_IF));
    check("d_req_ready",  32'(d_req_ready),  32'(exp_gnt == OWN_D));
    check("mem_en",       32'(mem_en),       32'(exp_gnt != OWN_NONE));
    exp_we = (exp_gnt == OWN_D && dwe) ? dbe : 4'b0000;
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_gnt == OWN_IF) begin
      check("mem_addr_if", 32'(mem_addr), 32'(ifa));
      check("mem_wdata_if", mem_wdata, 32'h0);
    end else if (exp_gnt == OWN_D) begin
      check("mem_addr_d", 32'(mem_addr), 32'(da));
      check("mem_wdata_d", mem_wdata, dwd);
    end
    if (queue_rsp && exp_gnt != OWN_NONE) begin
      e.data = exp_rsp;
      e.due  = cyc + 1;
      if (exp_gnt == OWN_IF) if_q.push_back(e);
      else                   d_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 32'h0, 4'h0, OWN_NONE, 32'h0);
  endtask

  // With reset held, requests are driven but nothing may be granted.
  task automatic check_in_reset(input string tag);
    @(negedge clk);
    check({tag, "_if_ready"}, 32'(if_req_ready), 32'h0);
    check({tag, "_d_ready"},  32'(d_req_ready),  32'h0);
    check({tag, "_mem_en"},   32'(mem_en),       32'h0);
    check({tag, "_mem_we"},   32'(mem_we),       32'h0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [DEPTH-1:0] A_INS = 10'h004;
  localparam logic [DEPTH-1:0] A_DAT = 10'h010;
  localparam logic [31:0]      INSN  = 32'h0050_0093;

  initial begin
    for (int i = 0; i < (1 << DEPTH); i++) ram[i] = 32'hA500_0000 | 32'(i);
    ram[A_INS] = INSN;
    ram[A_DAT] = 32'h0;
    mem_rdata  = 32'h0;

    rst_n        = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = A_INS;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b1;
    d_req_addr   = A_DAT;
    d_req_wdata  = 32'hFFFF_FFFF;
    d_req_be     = 4'hF;
    check_in_reset("rst0");
    check_in_reset("rst1");
    rst_n = 1'b1;

    // Fetch only, granted on the first edge after reset release.
    step(1, A_INS, 0, 0, '0, 32'h0, 4'h0, OWN_IF, INSN);
    idle(3);

    // Partial write then read-back in consecutive grants.
    step(0, '0, 1, 1, A_DAT, 32'hDEAD_BEEF, 4'b0011, OWN_D, 32'h0);
    step(0, '0, 1, 0, A_DAT, 32'h0, 4'h0, OWN_D, 32'h0000_BEEF);
    step(0, '0, 1, 1, A_DAT, 32'h1234_5678, 4'b1100, OWN_D, 32'h0);
    step(0, '0, 1, 0, A_DAT, 32'h0, 4'h0, OWN_D, 32'h1234_BEEF);
    idle(1);

    // Both valid continuously: four data wins, then the starved fetch wins.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) step(1, A_INS, 1, 0, A_DAT, 32'h0, 4'h0, OWN_IF, INSN);
      else            step(1, A_INS, 1, 0, A_DAT, 32'h0, 4'h0, OWN_D, 32'h1234_BEEF);
    end
    idle(1);

    // Fetch alone for ten cycles: back-to-back grants and responses.
    for (int i = 0; i < 10; i++) begin
      step(1, 10'h020 + 10'(i), 0, 0, '0, 32'h0, 4'h0, OWN_IF, 32'hA500_0020 + 32'(i));
    end

    // Counter is still 0 here, so data wins; the second grant is cut by reset.
    step(1, A_INS, 1, 0, A_DAT, 32'h0, 4'h0, OWN_D, 32'h1234_BEEF);
    step(1, A_INS, 1, 0, A_DAT, 32'h0, 4'h0, OWN_D, 32'h0, 1'b0);
    rst_n = 1'b0;
    check_in_reset("rst2");
    check_in_reset("rst3");
    rst_n = 1'b1;

    // Starvation count restarted at 0: four data wins before the fetch.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) step(1, A_INS, 1, 0, A_DAT, 32'h0, 4'h0, OWN_IF, INSN);
      else        step(1, A_INS, 1, 0, A_DAT, 32'h0, 4'h0, OWN_D, 32'h1234_BEEF);
    end
    idle(3);

    check("if_queue_drained", 32'(if_q.size()), 32'h0);
    check("d_queue_drained",  32'(d_q.size()),  32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
